// File: rtl/uart_tx_arb.sv
// Round-robin arbiter feeding three requesters' bytes into one uart_tx. Once a byte is granted,
// further grants wait until a full frame (plus guard bits) has elapsed.
module uart_tx_arb #(
    parameter int unsigned CLK_FREQ   = 40000,
    parameter int unsigned UART_BPS   = 1000,
    parameter int unsigned GUARD_BITS = 2
) (
    input  logic        clk_40k,
    input  logic        rst,
    input  logic [2:0]  req,
    input  logic [23:0] req_data,
    input  logic [2:0]  en_mask,
    output logic [2:0]  ack,
    output logic [1:0]  grant_id,
    output logic        busy,
    output logic [7:0]  tx_din,
    output logic        tx_start,
    output logic [15:0] frame_cnt
);

    localparam int unsigned CLK_DIV   = CLK_FREQ / UART_BPS;
    localparam int unsigned FRAME_CYC = CLK_DIV * (10 + GUARD_BITS);
    localparam int unsigned CNT_W     = (FRAME_CYC > 1) ? $clog2(FRAME_CYC) : 1;
    localparam logic [CNT_W-1:0] CntLast = CNT_W'(FRAME_CYC - 1);

    generate
        if (CLK_DIV == 0 || (CLK_DIV % 2) != 0) begin : g_bad_div
            $error("uart_tx_arb: CLK_FREQ/UART_BPS must be even and non-zero");
        end
    endgenerate

    typedef enum logic [0:0] {StIdle, StSend} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       grant_q, grant_d;
    logic [7:0]       din_q, din_d;
    logic [15:0]      fcnt_q, fcnt_d;
    logic [2:0]       ack_q, ack_d;
    logic             start_q, start_d;

    logic [2:0] elig;
    logic [1:0] p0, p1, p2, sel;
    logic [7:0] sel_byte;

    assign elig = req & en_mask;

    // Search order begins just after the last granted requester.
    always_comb begin
        unique case (grant_q)
            2'd0:    begin p0 = 2'd1; p1 = 2'd2; p2 = 2'd0; end
            2'd1:    begin p0 = 2'd2; p1 = 2'd0; p2 = 2'd1; end
            default: begin p0 = 2'd0; p1 = 2'd1; p2 = 2'd2; end
        endcase
        if (elig[p0]) begin
            sel = p0;
        end else if (elig[p1]) begin
            sel = p1;
        end else begin
            sel = p2;
        end
    end

    always_comb begin
        unique case (sel)
            2'd0:    sel_byte = req_data[7:0];
            2'd1:    sel_byte = req_data[15:8];
            default: sel_byte = req_data[23:16];
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        grant_d = grant_q;
        din_d   = din_q;
        fcnt_d  = fcnt_q;
        ack_d   = 3'b000;
        start_d = 1'b0;
        case (state_q)
            StIdle: begin
                if (|elig) begin
                    state_d = StSend;
                    cnt_d   = '0;
                    grant_d = sel;
                    din_d   = sel_byte;
                    fcnt_d  = fcnt_q + 16'd1;
                    ack_d   = 3'b001 << sel;
                    start_d = 1'b1;
                end
            end
            StSend: begin
                if (cnt_q == CntLast) begin
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk_40k or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            grant_q <= 2'd2;
            din_q   <= 8'h00;
            fcnt_q  <= 16'h0000;
            ack_q   <= 3'b000;
            start_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            grant_q <= grant_d;
            din_q   <= din_d;
            fcnt_q  <= fcnt_d;
            ack_q   <= ack_d;
            start_q <= start_d;
        end
    end

    assign ack       = ack_q;
    assign grant_id  = grant_q;
    assign busy      = (state_q == StSend);
    assign tx_din    = din_q;
    assign tx_start  = start_q;
    assign frame_cnt = fcnt_q;

endmodule
